// File: rtl/rojobot_pkg.sv
// rtl/rojobot_pkg.sv - shared types and constants for the Rojobot update controller
package rojobot_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        PEND = 1'b1
    } upd_state_t;

    localparam logic [7:0] STOP_CODE_DEF = 8'h00;
    localparam logic [7:0] OVR_MAX       = 8'hFF;

    // BotInfo word layout: {LocX, LocY, Sensors, BotInfo}
    localparam int LOCX_MSB    = 31;
    localparam int LOCX_LSB    = 24;
    localparam int LOCY_MSB    = 23;
    localparam int LOCY_LSB    = 16;
    localparam int SENSORS_MSB = 15;
    localparam int SENSORS_LSB = 8;
    localparam int INFO_MSB    = 7;
    localparam int INFO_LSB    = 0;

endpackage

// File: rtl/rojobot_upd_sync.sv
// rtl/rojobot_upd_sync.sv - update strobe synchronizer and rising-edge detector
module rojobot_upd_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rstn,
    input  logic i_async,
    output logic o_edge
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   sync_out_d_q;
    logic                   sync_out;

    assign sync_out = sync_q[SYNC_STAGES-1];

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            sync_q       <= '0;
            sync_out_d_q <= 1'b0;
        end else begin
            sync_q       <= {sync_q[SYNC_STAGES-2:0], i_async};
            sync_out_d_q <= sync_out;
        end
    end

    // A held-high strobe yields a single one-cycle pulse.
    assign o_edge = sync_out & ~sync_out_d_q;

endmodule

// File: rtl/rojobot_upd_ctrl.sv
// rtl/rojobot_upd_ctrl.sv - Rojobot update/interrupt handshake, motion register and watchdog
module rojobot_upd_ctrl
    import rojobot_pkg::*;
#(
    parameter int         SYNC_STAGES  = 2,
    parameter int         WDOG_UPDATES = 16,
    parameter logic [7:0] STOP_CODE    = STOP_CODE_DEF
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        i_upd_async,
    input  logic [31:0] i_botinfo,
    input  logic        i_int_ack,
    input  logic        i_motctl_we,
    input  logic [7:0]  i_motctl_wdata,
    input  logic        i_clr_ovr,
    output logic        o_upd_sync,
    output logic [31:0] o_botinfo_snap,
    output logic [7:0]  o_motctl,
    output logic [7:0]  o_overrun_cnt,
    output logic        o_wdog_trip
);

    localparam logic [15:0] WDOG_MAX = 16'(WDOG_UPDATES);

    upd_state_t  state_q, state_d;
    logic [31:0] snap_q, snap_d;
    logic [7:0]  motctl_q, motctl_d;
    logic [7:0]  ovr_q, ovr_d;
    logic        trip_q, trip_d;
    logic [15:0] wdog_cnt_q, wdog_cnt_d;
    logic        ack_d_q;
    logic        upd_edge;
    logic        ack_edge;

    rojobot_upd_sync #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_upd_sync (
        .clk     (clk),
        .rstn    (rstn),
        .i_async (i_upd_async),
        .o_edge  (upd_edge)
    );

    assign ack_edge = i_int_ack & ~ack_d_q;

    always_comb begin
        state_d    = state_q;
        snap_d     = snap_q;
        motctl_d   = motctl_q;
        ovr_d      = ovr_q;
        trip_d     = trip_q;
        wdog_cnt_d = wdog_cnt_q;

        case (state_q)
            IDLE: begin
                if (upd_edge) begin
                    state_d = PEND;
                    snap_d  = i_botinfo;
                end
            end
            PEND: begin
                if (upd_edge) begin
                    snap_d = i_botinfo;
                    // A simultaneous ack consumes the old update, so it is not an overrun.
                    if (!ack_edge && ovr_q != OVR_MAX) begin
                        ovr_d = ovr_q + 8'd1;
                    end
                end else if (ack_edge) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        if (i_clr_ovr) begin
            ovr_d = 8'd0;
        end

        if (WDOG_UPDATES > 0) begin
            if (upd_edge && !trip_q && wdog_cnt_q != WDOG_MAX) begin
                wdog_cnt_d = wdog_cnt_q + 16'd1;
                if (wdog_cnt_q + 16'd1 == WDOG_MAX) begin
                    trip_d   = 1'b1;
                    motctl_d = STOP_CODE;
                end
            end
        end

        // The core writing a command proves it is alive; this overrides any trip.
        if (i_motctl_we) begin
            motctl_d   = i_motctl_wdata;
            trip_d     = 1'b0;
            wdog_cnt_d = 16'd0;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q    <= IDLE;
            snap_q     <= 32'd0;
            motctl_q   <= STOP_CODE;
            ovr_q      <= 8'd0;
            trip_q     <= 1'b0;
            wdog_cnt_q <= 16'd0;
            ack_d_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            snap_q     <= snap_d;
            motctl_q   <= motctl_d;
            ovr_q      <= ovr_d;
            trip_q     <= trip_d;
            wdog_cnt_q <= wdog_cnt_d;
            ack_d_q    <= i_int_ack;
        end
    end

    assign o_upd_sync     = (state_q == PEND);
    assign o_botinfo_snap = snap_q;
    assign o_motctl       = motctl_q;
    assign o_overrun_cnt  = ovr_q;
    assign o_wdog_trip    = trip_q;

endmodule

// File: doc/rojobot_upd_ctrl.md
Name: rojobot_upd_ctrl

Overview:
- Single-clock controller that sequences the Rojobot update/interrupt handshake for the SweRVolf core and owns the motion-control register driven into the Rojobot.
- Synchronizes the Rojobot update strobe into the core clock and snapshots the 32-bit BotInfo word, {LocX, LocY, Sensors, BotInfo}.
- Raises a sticky update flag and clears it on a core acknowledge edge; counts overruns.
- Runs a watchdog that forces the bot to STOP if the core stops issuing motion commands.
- Replaces the ad-hoc handshake flip-flop; sits between rojobot31_0 and the core GPIO at 0x1800/0x1600.

Parameters:
- SYNC_STAGES, 2, flip-flop depth of the i_upd_async synchronizer; legal range 2..4.
- WDOG_UPDATES, 16, number of Rojobot updates with no motion write before the watchdog trips; 0 disables the watchdog.
- STOP_CODE, 8'h00, MotCtl value forced on reset and on watchdog trip.

Ports:
- clk  in  1  core clock; all logic on the rising edge.
- rstn  in  1  asynchronous active-low reset.
- i_upd_async  in  1  Rojobot upd_sysregs, from a foreign clock (clk_75).
- i_botinfo  in  32  Rojobot registers; stable ≥ SYNC_STAGES+2 clk cycles after i_upd_async rises.
- i_int_ack  in  1  core acknowledge level (GPIO bit); only its rising edge is used.
- i_motctl_we  in  1  one-cycle write strobe for the motion register.
- i_motctl_wdata  in  8  motion command.
- i_clr_ovr  in  1  one-cycle clear of the overrun counter.
- o_upd_sync  out  1  sticky "new BotInfo available" flag, read as IO_BotUpdt_Sync.
- o_botinfo_snap  out  32  BotInfo captured at the last accepted update.
- o_motctl  out  8  MotCtl_in to the Rojobot.
- o_overrun_cnt  out  8  updates received while a previous one was unacknowledged; saturates at 255.
- o_wdog_trip  out  1  watchdog has forced STOP_CODE.

Behaviour:
- Reset values (rstn low, asynchronous):
  - o_upd_sync=0, o_botinfo_snap=0, o_motctl=STOP_CODE, o_overrun_cnt=0, o_wdog_trip=0.
  - Synchronizer and edge registers 0, FSM in IDLE, watchdog counter 0.
- Update edge detection:
  - upd_edge = sync_out & ~sync_out_d.
  - First clk edge sampling i_upd_async=1 is edge 1. upd_edge is true in the cycle after edge SYNC_STAGES; capture happens at edge SYNC_STAGES+1.
  - Latency from edge 1 to o_upd_sync=1 is exactly SYNC_STAGES+1 edges.
  - A held-high strobe produces one upd_edge only.
- Ack detection: ack_edge = i_int_ack & ~ack_d, with ack_d registered. A level held high never re-clears.
- FSM states and transitions:
  - IDLE --upd_edge--> PEND: snap<=i_botinfo, o_upd_sync<=1. ack_edge in IDLE is ignored.
  - PEND, ack_edge only --> IDLE: o_upd_sync<=0; snap holds.
  - PEND, upd_edge only: stay in PEND; snap<=i_botinfo (newest wins); o_overrun_cnt+1, saturating at 255.
  - PEND, upd_edge and ack_edge in the same cycle: stay in PEND; snap<=new; o_upd_sync stays 1; no overrun increment.
- Overrun clear: i_clr_ovr zeroes the counter next edge. If it coincides with an increment, the clear wins and the result is 0.
- Motion register: i_motctl_we -> o_motctl<=i_motctl_wdata next edge; also clears o_wdog_trip and the watchdog counter.
- Watchdog (WDOG_UPDATES>0):
  - Counter increments on each upd_edge, saturating at WDOG_UPDATES.
  - On the edge where it reaches WDOG_UPDATES: o_wdog_trip<=1 and o_motctl<=STOP_CODE.
  - While tripped, further updates change nothing.
  - Write and upd_edge in the same cycle: the write wins and the counter becomes 0.
- Watchdog disabled (WDOG_UPDATES=0): counter is held at 0 and o_wdog_trip stays 0.
- Reset asserted mid-handshake returns all outputs to their reset values immediately. A pending update is lost.

Decomposition:
- Package rojobot_pkg:
  - typedef enum logic {IDLE, PEND} upd_state_t.
  - Default STOP_CODE.
  - BotInfo field slices: LOCX [31:24], LOCY [23:16], SENSORS [15:8], INFO [7:0].
  - OVR_MAX = 8'hFF.
- Sub-module rojobot_upd_sync: SYNC_STAGES-deep synchronizer plus rising-edge detector, outputting upd_edge. Instantiated once.

Test Plan:
- Reset release, SYNC_STAGES=2; i_upd_async high 20 cycles with i_botinfo=32'h1234_5678 -> o_upd_sync=1 exactly 3 edges after first sample; snap=32'h12345678; exactly one capture.
- Pending flag, i_int_ack raised and held high -> o_upd_sync=0 next edge. A second update then sets the flag again despite ack still being high.
- Three updates (botinfo A, B, C), no ack -> o_overrun_cnt=2, snap=C. Then i_clr_ovr -> counter 0. Forcing 300 overruns -> counter saturates at 255.
- upd_edge and ack_edge in the same cycle while PEND -> o_upd_sync stays 1, snap updated, o_overrun_cnt unchanged.
- WDOG_UPDATES=4, write 8'h33, then 4 updates with no write:
  - o_motctl=8'h33 through the 3rd update.
  - On the 4th update o_motctl=8'h00 and o_wdog_trip=1.
  - Write 8'h11 -> o_motctl=8'h11, o_wdog_trip=0.
- rstn pulsed low asynchronously mid-PEND with overruns present -> all outputs at reset values without waiting for a clk edge. o_motctl=STOP_CODE.
